// File: rtl/ifc_pkg.sv
// Shared constants for the buffered multi-channel reduction block:
// reduction mode encodings and the width of the consumed-result counter.
package ifc_pkg;

    localparam logic [1:0] MODE_OR  = 2'b00;
    localparam logic [1:0] MODE_AND = 2'b01;
    localparam logic [1:0] MODE_XOR = 2'b10;

    localparam int CNT_W = 16;

endpackage

// File: rtl/ifc_fifo.sv
// Circular FIFO with enqueue/dequeue handshakes and an explicit occupancy count.
// There is no bypass path: a full buffer refuses an enqueue even when it is popped in the same cycle.
module ifc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enq_en,
    input  logic [WIDTH-1:0] enq_data,
    output logic             enq_rdy,
    input  logic             deq_en,
    output logic [WIDTH-1:0] deq_data,
    output logic             deq_rdy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_enq;
    logic             do_deq;

    assign enq_rdy  = (count != CW'(DEPTH));
    assign deq_rdy  = (count != '0);
    assign do_enq   = enq_en && enq_rdy;
    assign do_deq   = deq_en && deq_rdy;
    assign deq_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge CLK) begin
        if (do_enq) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ifc_reduce.sv
// NUM_IN buffered input channels reduced bitwise (OR/AND/XOR) into one result per dequeue.
// A result is offered only when every channel holds at least one word.
module ifc_reduce
    import ifc_pkg::*;
#(
    parameter int NUM_IN = 2,
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_en,
    output logic [NUM_IN-1:0]       in_rdy,
    input  logic [1:0]              mode,
    input  logic                    y_en,
    output logic [WIDTH-1:0]        y_data,
    output logic                    y_rdy,
    output logic [CNT_W-1:0]        y_count
);

    logic [WIDTH-1:0]  heads [NUM_IN];
    logic [NUM_IN-1:0] ch_nonempty;
    logic              do_deq;
    logic [WIDTH-1:0]  acc;

    assign y_rdy  = &ch_nonempty;
    assign do_deq = y_en && y_rdy;

    for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
        ifc_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .CLK      (CLK),
            .RST      (RST),
            .enq_en   (in_en[g]),
            .enq_data (in_data[g*WIDTH +: WIDTH]),
            .enq_rdy  (in_rdy[g]),
            .deq_en   (do_deq),
            .deq_data (heads[g]),
            .deq_rdy  (ch_nonempty[g])
        );
    end

    // Fold starts at channel 0; the reserved mode value falls back to OR.
    always_comb begin
        acc = heads[0];
        for (int i = 1; i < NUM_IN; i++) begin
            case (mode)
                MODE_AND: acc = acc & heads[i];
                MODE_XOR: acc = acc ^ heads[i];
                default:  acc = acc | heads[i];
            endcase
        end
        y_data = y_rdy ? acc : '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            y_count <= '0;
        end else if (do_deq) begin
            y_count <= y_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ifc_reduce.sv
// Self-checking bench for ifc_reduce: directed scenarios plus randomized traffic
// compared against a queue-based model of the channel buffers.
module tb_ifc_reduce;

    localparam int NUM_IN = 2;
    localparam int WIDTH  = 8;
    localparam int DEPTH  = 4;

    logic                    CLK = 1'b0;
    logic                    RST;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_en;
    logic [NUM_IN-1:0]       in_rdy;
    logic [1:0]              mode;
    logic                    y_en;
    logic [WIDTH-1:0]        y_data;
    logic                    y_rdy;
    logic [15:0]             y_count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mq [NUM_IN][$];
    logic [15:0]      m_count;

    always #5 CLK = ~CLK;

    ifc_reduce #(
        .NUM_IN (NUM_IN),
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .in_data (in_data),
        .in_en   (in_en),
        .in_rdy  (in_rdy),
        .mode    (mode),
        .y_en    (y_en),
        .y_data  (y_data),
        .y_rdy   (y_rdy),
        .y_count (y_count)
    );

    function automatic logic m_yrdy();
        for (int c = 0; c < NUM_IN; c++) begin
            if (mq[c].size() == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [NUM_IN-1:0] m_inrdy();
        logic [NUM_IN-1:0] r;
        for (int c = 0; c < NUM_IN; c++) r[c] = (mq[c].size() < DEPTH);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] exp_y();
        logic [WIDTH-1:0] a;
        if (!m_yrdy()) return '0;
        a = mq[0][0];
        for (int c = 1; c < NUM_IN; c++) begin
            if (mode == 2'b01)      a = a & mq[c][0];
            else if (mode == 2'b10) a = a ^ mq[c][0];
            else                    a = a | mq[c][0];
        end
        return a;
    endfunction

    // Applies one cycle of stimulus at a falling edge, updates the model at the
    // rising edge, and returns at the next falling edge with inputs idle.
    task automatic tick(input logic rst, input logic [NUM_IN-1:0] en,
                        input logic [NUM_IN*WIDTH-1:0] d, input logic ye);
        logic              deq;
        logic [NUM_IN-1:0] acc;
        RST = rst; in_en = en; in_data = d; y_en = ye;
        deq = ye && m_yrdy();
        acc = en & m_inrdy();
        @(posedge CLK);
        if (rst) begin
            for (int c = 0; c < NUM_IN; c++) mq[c].delete();
            m_count = '0;
        end else begin
            for (int c = 0; c < NUM_IN; c++) begin
                if (deq) void'(mq[c].pop_front());
                if (acc[c]) mq[c].push_back(d[c*WIDTH +: WIDTH]);
            end
            if (deq) m_count = m_count + 16'd1;
        end
        @(negedge CLK);
        RST = 1'b0; in_en = '0; y_en = 1'b0;
    endtask

    task automatic test_reset();
        tick(1'b1, '0, '0, 1'b0);
        tick(1'b0, '0, '0, 1'b0);
        total++; if (in_rdy !== 2'b11) begin bad++; $display("FAIL reset_in_rdy: got %b expected 11", in_rdy); end
        total++; if (y_rdy !== 1'b0) begin bad++; $display("FAIL reset_y_rdy: got %b expected 0", y_rdy); end
        total++; if (y_data !== 8'h00) begin bad++; $display("FAIL reset_y_data: got %h expected 00", y_data); end
        total++; if (y_count !== 16'd0) begin bad++; $display("FAIL reset_y_count: got %0d expected 0", y_count); end
    endtask

    task automatic test_modes();
        mode = 2'b00;
        tick(1'b0, 2'b11, {8'hF0, 8'h0F}, 1'b0);
        total++; if (y_rdy !== 1'b1) begin bad++; $display("FAIL basic_y_rdy: got %b expected 1", y_rdy); end
        total++; if (y_data !== 8'hFF) begin bad++; $display("FAIL basic_or: got %h expected ff", y_data); end
        mode = 2'b01; #1;
        total++; if (y_data !== 8'h00) begin bad++; $display("FAIL basic_and: got %h expected 00", y_data); end
        mode = 2'b10; #1;
        total++; if (y_data !== 8'hFF) begin bad++; $display("FAIL basic_xor: got %h expected ff", y_data); end
        mode = 2'b11; #1;
        total++; if (y_data !== 8'hFF) begin bad++; $display("FAIL basic_reserved_or: got %h expected ff", y_data); end
        mode = 2'b00;
        tick(1'b0, '0, '0, 1'b1);
        total++; if (y_rdy !== 1'b0) begin bad++; $display("FAIL basic_pop_y_rdy: got %b expected 0", y_rdy); end
        total++; if (y_count !== 16'd1) begin bad++; $display("FAIL basic_pop_y_count: got %0d expected 1", y_count); end
    endtask

    task automatic test_full();
        logic [WIDTH-1:0] e;
        mode = 2'b10;
        for (int k = 0; k < DEPTH; k++) tick(1'b0, 2'b01, {8'h00, 8'(k + 1)}, 1'b0);
        total++; if (in_rdy !== 2'b10) begin bad++; $display("FAIL full_in_rdy: got %b expected 10", in_rdy); end
        tick(1'b0, 2'b01, {8'h00, 8'h05}, 1'b1);
        total++; if (in_rdy !== 2'b10) begin bad++; $display("FAIL full_ignored_in_rdy: got %b expected 10", in_rdy); end
        total++; if (y_rdy !== 1'b0) begin bad++; $display("FAIL full_y_rdy: got %b expected 0", y_rdy); end
        total++; if (y_data !== 8'h00) begin bad++; $display("FAIL full_y_data: got %h expected 00", y_data); end
        for (int k = 0; k < DEPTH; k++) tick(1'b0, 2'b10, {8'(k + 16), 8'h00}, 1'b0);
        total++; if (in_rdy !== 2'b00) begin bad++; $display("FAIL both_full_in_rdy: got %b expected 00", in_rdy); end
        for (int k = 0; k < DEPTH; k++) begin
            e = 8'(k + 1) ^ 8'(k + 16);
            total++; if (y_data !== e || y_rdy !== 1'b1) begin
                bad++; $display("FAIL full_xor_%0d: got %h rdy %b expected %h rdy 1", k, y_data, y_rdy, e);
            end
            tick(1'b0, '0, '0, 1'b1);
            if (k == 0) begin
                total++; if (in_rdy !== 2'b11) begin bad++; $display("FAIL full_rise_in_rdy: got %b expected 11", in_rdy); end
            end
        end
        total++; if (y_rdy !== 1'b0) begin bad++; $display("FAIL full_drained_y_rdy: got %b expected 0", y_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] start;
        int          gaps;
        gaps  = 0;
        mode  = 2'b10;
        start = y_count;
        tick(1'b0, 2'b11, 16'($urandom), 1'b0);
        for (int k = 0; k < 20; k++) begin
            if (y_rdy !== 1'b1 || in_rdy !== 2'b11 || y_data !== exp_y()) gaps++;
            tick(1'b0, 2'b11, 16'($urandom), 1'b1);
        end
        total++; if (gaps != 0) begin bad++; $display("FAIL stream_cycles: got %0d bad cycles expected 0", gaps); end
        total++; if (y_count !== 16'(start + 16'd20)) begin
            bad++; $display("FAIL stream_y_count: got %0d expected %0d", y_count, 16'(start + 16'd20));
        end
    endtask

    task automatic test_mid_reset();
        tick(1'b0, 2'b11, 16'($urandom), 1'b0);
        tick(1'b0, 2'b11, 16'($urandom), 1'b0);
        total++; if (y_rdy !== 1'b1) begin bad++; $display("FAIL half_y_rdy: got %b expected 1", y_rdy); end
        tick(1'b1, 2'b11, 16'($urandom), 1'b1);
        total++; if (in_rdy !== 2'b11 || y_rdy !== 1'b0 || y_data !== 8'h00 || y_count !== 16'd0) begin
            bad++; $display("FAIL mid_reset: got in_rdy %b y_rdy %b y_data %h y_count %0d expected 11 0 00 0",
                            in_rdy, y_rdy, y_data, y_count);
        end
        tick(1'b0, '0, '0, 1'b0);
        total++; if (y_rdy !== 1'b0) begin bad++; $display("FAIL post_reset_y_rdy: got %b expected 0", y_rdy); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            mode = 2'($urandom_range(0, 3));
            #1;
            total++;
            if (in_rdy !== m_inrdy() || y_rdy !== m_yrdy() || y_data !== exp_y() || y_count !== m_count) begin
                bad++;
                $display("FAIL random_%0d: got in_rdy %b y_rdy %b y_data %h y_count %0d expected %b %b %h %0d",
                         k, in_rdy, y_rdy, y_data, y_count, m_inrdy(), m_yrdy(), exp_y(), m_count);
            end
            tick(1'b0, 2'($urandom), 16'($urandom), ($urandom_range(0, 2) == 0));
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, '0, '0, 1'b0);
        tick(1'b0, 2'b11, 16'($urandom), 1'b0);
        for (int k = 0; k < 65537; k++) tick(1'b0, 2'b11, 16'($urandom), 1'b1);
        total++; if (y_count !== 16'd1) begin bad++; $display("FAIL wrap_y_count: got %0d expected 1", y_count); end
        total++; if (y_count !== m_count) begin bad++; $display("FAIL wrap_model: got %0d expected %0d", y_count, m_count); end
    endtask

    initial begin
        RST = 1'b0; in_en = '0; in_data = '0; y_en = 1'b0; mode = 2'b00; m_count = '0;
        @(negedge CLK);
        test_reset();
        test_modes();
        test_full();
        test_back_to_back();
        test_mid_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
